// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active low.
package seven_seg_pkg;

  // Scan FSM states: anodes dark between digits, then one digit driven.
  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  // All segments off (active low).
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Nibble to active-low segment pattern, indexed by the hex value.
  localparam logic [6:0] SEG_DECODE [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg7
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble_in,
  output logic [6:0] seg_out
);

  // Straight table lookup; every nibble value has a glyph.
  always_comb begin
    seg_out = SEG_DECODE[nibble_in];
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed scanner for a common-anode multi-digit 7-segment display.
// The slow scan clock from the divider is treated as data: it is synchronized,
// edge-detected, and each rising edge advances the display by one digit.
// Display data is captured once per frame so a frame never shows mixed values.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    CLK_IN,
  input  logic                    RST_IN,
  input  logic                    SCAN_CLK_IN,
  input  logic [4*NUM_DIGITS-1:0] VALUE_IN,
  input  logic [NUM_DIGITS-1:0]   DP_IN,
  input  logic [NUM_DIGITS-1:0]   DIGIT_EN_IN,
  input  logic                    LZB_IN,
  output logic [NUM_DIGITS-1:0]   AN_OUT,
  output logic [6:0]              SEG_OUT,
  output logic                    DP_OUT,
  output logic                    FRAME_OUT
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = (BLANK_CYCLES < 2) ? 1 : $clog2(BLANK_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLANK_CYCLES);

  // Scan clock synchronizer and edge-detect history.
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic scan_prev_q, scan_prev_d;

  // Scan FSM state.
  scan_state_e      state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Per-frame shadow copy of the display inputs.
  logic [4*NUM_DIGITS-1:0] value_sh_q, value_sh_d;
  logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
  logic [NUM_DIGITS-1:0]   en_sh_q, en_sh_d;
  logic                    lzb_sh_q, lzb_sh_d;

  // Registered display outputs.
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_q, frame_d;

  // Derived combinational signals.
  logic                  step;
  logic                  last_digit;
  logic [3:0]            cur_nibble;
  logic [6:0]            dec_seg;
  logic                  zero_run;
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  visible;

  // The divided clock is an asynchronous level here, so resynchronize it
  // and keep one extra sample to compare against for rising-edge detection.
  always_comb begin
    sync1_d     = SCAN_CLK_IN;
    sync2_d     = sync1_q;
    scan_prev_d = sync2_q;
  end

  assign step       = sync2_q & ~scan_prev_q;
  assign last_digit = (index_q == LAST_IDX);
  assign cur_nibble = value_sh_q[{index_q, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .nibble_in (cur_nibble),
    .seg_out   (dec_seg)
  );

  // Leading-zero mask: walk down from the top digit while every nibble seen
  // so far is zero; digit 0 always stays lit so a zero value still shows "0".
  always_comb begin
    zero_run = 1'b1;
    lz_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (value_sh_q[4*i +: 4] == 4'h0);
      if (i != 0) begin
        lz_blank[i] = lzb_sh_q & zero_run;
      end
    end
  end

  assign visible = en_sh_q[index_q] & ~lz_blank[index_q];

  // Next-state logic: a step always wins and restarts the blanking gap; the
  // outputs are computed for the state being entered so they land together.
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    cnt_d      = cnt_q;
    value_sh_d = value_sh_q;
    dp_sh_d    = dp_sh_q;
    en_sh_d    = en_sh_q;
    lzb_sh_d   = lzb_sh_q;
    frame_d    = 1'b0;
    an_d       = '1;
    seg_d      = SEG_OFF;
    dp_d       = 1'b1;

    if (step) begin
      index_d = last_digit ? '0 : index_q + 1'b1;
      state_d = BLANK;
      cnt_d   = CNT_LOAD;
      if (last_digit) begin
        value_sh_d = VALUE_IN;
        dp_sh_d    = DP_IN;
        en_sh_d    = DIGIT_EN_IN;
        lzb_sh_d   = LZB_IN;
        frame_d    = 1'b1;
      end
    end else begin
      if (state_q == BLANK) begin
        if (cnt_q == '0) begin
          state_d = DRIVE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      if ((state_d == DRIVE) && visible) begin
        an_d[index_q] = 1'b0;
        seg_d         = dec_seg;
        dp_d          = ~dp_sh_q[index_q];
      end
    end
  end

  // All state and outputs register here; reset parks the scan on the last
  // digit so the very first step wraps and latches a fresh frame.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      scan_prev_q <= 1'b0;
      state_q     <= BLANK;
      index_q     <= LAST_IDX;
      cnt_q       <= '0;
      value_sh_q  <= '0;
      dp_sh_q     <= '0;
      en_sh_q     <= '0;
      lzb_sh_q    <= 1'b0;
      an_q        <= '1;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
      frame_q     <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      scan_prev_q <= scan_prev_d;
      state_q     <= state_d;
      index_q     <= index_d;
      cnt_q       <= cnt_d;
      value_sh_q  <= value_sh_d;
      dp_sh_q     <= dp_sh_d;
      en_sh_q     <= en_sh_d;
      lzb_sh_q    <= lzb_sh_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      frame_q     <= frame_d;
    end
  end

  assign AN_OUT    = an_q;
  assign SEG_OUT   = seg_q;
  assign DP_OUT    = dp_q;
  assign FRAME_OUT = frame_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner. Two instances share all inputs:
// one with a 16-cycle blanking gap and one with no gap.
module tb_seven_seg_scanner;

  localparam int NUM_DIGITS = 4;
  localparam int BLANK_A    = 16;
  localparam int BLANK_B    = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        scan;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  en_in;
  logic        lzb;

  logic [3:0]  an_a, an_b;
  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b;
  logic        frame_a, frame_b;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame;
  } exp_t;

  exp_t exp_q[$];
  exp_t e1, e2;

  int          m_idx;
  logic [15:0] m_val;
  logic [3:0]  m_dp, m_en;
  logic        m_lzb;

  always #5 clk = ~clk;

  seven_seg_scanner #(.NUM_DIGITS(NUM_DIGITS), .BLANK_CYCLES(BLANK_A)) dut_a (
    .CLK_IN(clk), .RST_IN(rst), .SCAN_CLK_IN(scan), .VALUE_IN(value),
    .DP_IN(dp_in), .DIGIT_EN_IN(en_in), .LZB_IN(lzb),
    .AN_OUT(an_a), .SEG_OUT(seg_a), .DP_OUT(dp_a), .FRAME_OUT(frame_a)
  );

  seven_seg_scanner #(.NUM_DIGITS(NUM_DIGITS), .BLANK_CYCLES(BLANK_B)) dut_b (
    .CLK_IN(clk), .RST_IN(rst), .SCAN_CLK_IN(scan), .VALUE_IN(value),
    .DP_IN(dp_in), .DIGIT_EN_IN(en_in), .LZB_IN(lzb),
    .AN_OUT(an_b), .SEG_OUT(seg_b), .DP_OUT(dp_b), .FRAME_OUT(frame_b)
  );

  function automatic logic [6:0] refSeg(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, wanted %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_idx = NUM_DIGITS - 1;
    m_val = '0;
    m_dp  = '0;
    m_en  = '0;
    m_lzb = 1'b0;
  endtask

  // Raise the scan clock at a falling edge, advance the reference model and
  // queue what the display should show for the digit this step selects.
  task automatic applyStimulus();
    exp_t e;
    logic all_zero;
    logic vis;
    @(negedge clk);
    scan = 1'b1;
    m_idx = (m_idx == NUM_DIGITS - 1) ? 0 : m_idx + 1;
    e.frame = (m_idx == 0);
    if (e.frame) begin
      m_val = value;
      m_dp  = dp_in;
      m_en  = en_in;
      m_lzb = lzb;
    end
    all_zero = 1'b1;
    for (int i = m_idx; i < NUM_DIGITS; i++) begin
      if (m_val[4*i +: 4] != 4'h0) all_zero = 1'b0;
    end
    vis = m_en[m_idx] && !(m_lzb && (m_idx != 0) && all_zero);
    e.an  = 4'hF;
    e.seg = 7'h7F;
    e.dp  = 1'b1;
    if (vis) begin
      e.an[m_idx] = 1'b0;
      e.seg       = refSeg(m_val[4*m_idx +: 4]);
      e.dp        = ~m_dp[m_idx];
    end
    exp_q.push_back(e);
  endtask

  task automatic popExp(output exp_t e);
    if (exp_q.size() == 0) begin
      checkOutput("queue_empty", 32'(exp_q.size()), 32'd1);
      e = '1;
    end else begin
      e = exp_q.pop_front();
    end
  endtask

  // Follows one step from applyStimulus: the step lands on the third clock
  // edge, the zero-gap instance drives on the next edge, and the 16-cycle
  // instance stays dark until BLANK_A+1 edges after the step.
  task automatic collectStep();
    exp_t e;
    repeat (3) @(posedge clk);
    #1;
    popExp(e);
    checkOutput("frame_a", 32'(frame_a), 32'(e.frame));
    checkOutput("frame_b", 32'(frame_b), 32'(e.frame));
    checkOutput("an_step_a", 32'(an_a), 32'hF);
    checkOutput("an_step_b", 32'(an_b), 32'hF);
    @(negedge clk);
    scan = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("frame_end_a", 32'(frame_a), 32'd0);
    checkOutput("an_b", 32'(an_b), 32'(e.an));
    checkOutput("seg_b", 32'(seg_b), 32'(e.seg));
    checkOutput("dp_b", 32'(dp_b), 32'(e.dp));
    repeat (BLANK_A - 1) @(posedge clk);
    #1;
    checkOutput("an_gap_a", 32'(an_a), 32'hF);
    @(posedge clk);
    #1;
    checkOutput("an_a", 32'(an_a), 32'(e.an));
    checkOutput("seg_a", 32'(seg_a), 32'(e.seg));
    checkOutput("dp_a", 32'(dp_a), 32'(e.dp));
  endtask

  task automatic doStep();
    applyStimulus();
    collectStep();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    scan  = 1'b0;
    value = '0;
    dp_in = '0;
    en_in = 4'hF;
    lzb   = 1'b0;
    modelReset();

    // Reset held while the scan clock toggles: outputs stay at reset values.
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      scan = ((c / 2) % 2) == 1;
      @(posedge clk);
      #1;
      checkOutput("rst_an_a", 32'(an_a), 32'hF);
      checkOutput("rst_seg_a", 32'(seg_a), 32'h7F);
      checkOutput("rst_dp_a", 32'(dp_a), 32'd1);
      checkOutput("rst_frame_a", 32'(frame_a), 32'd0);
      checkOutput("rst_an_b", 32'(an_b), 32'hF);
    end
    @(negedge clk);
    scan = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Plain hex scan.
    value = 16'h12AF;
    repeat (4) doStep();

    // Leading-zero blanking, including an all-zero value.
    value = 16'h0005;
    lzb   = 1'b1;
    repeat (4) doStep();
    value = 16'h0000;
    repeat (4) doStep();

    // Mid-frame input change waits for the next frame latch.
    value = 16'h1111;
    lzb   = 1'b0;
    repeat (2) doStep();
    value = 16'h2222;
    repeat (3) doStep();

    // Two steps five cycles apart: the gap restarts on the second step.
    applyStimulus();
    repeat (2) @(negedge clk);
    scan = 1'b0;
    @(posedge clk);
    #1;
    popExp(e1);
    checkOutput("dbl_frame1_a", 32'(frame_a), 32'(e1.frame));
    @(posedge clk);
    #1;
    checkOutput("dbl_an1_b", 32'(an_b), 32'(e1.an));
    checkOutput("dbl_seg1_b", 32'(seg_b), 32'(e1.seg));
    @(negedge clk);
    applyStimulus();
    repeat (3) @(posedge clk);
    #1;
    popExp(e2);
    checkOutput("dbl_frame2_a", 32'(frame_a), 32'(e2.frame));
    checkOutput("dbl_step2_a", 32'(an_a), 32'hF);
    checkOutput("dbl_step2_b", 32'(an_b), 32'hF);
    @(negedge clk);
    scan = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("dbl_an2_b", 32'(an_b), 32'(e2.an));
    repeat (BLANK_A - 1) @(posedge clk);
    #1;
    checkOutput("dbl_reload_a", 32'(an_a), 32'hF);
    @(posedge clk);
    #1;
    checkOutput("dbl_an2_a", 32'(an_a), 32'(e2.an));
    checkOutput("dbl_seg2_a", 32'(seg_a), 32'(e2.seg));

    // Decimal point on digit 2 only.
    dp_in = 4'b0100;
    value = 16'h89CE;
    repeat (5) doStep();

    // Digit 2 disabled.
    dp_in = 4'b0000;
    en_in = 4'b1011;
    value = 16'h3E7D;
    repeat (4) doStep();

    // Reset while digit 3 is being driven.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_an_a", 32'(an_a), 32'hF);
    checkOutput("midrst_seg_a", 32'(seg_a), 32'h7F);
    checkOutput("midrst_dp_a", 32'(dp_a), 32'd1);
    checkOutput("midrst_an_b", 32'(an_b), 32'hF);
    checkOutput("midrst_seg_b", 32'(seg_b), 32'h7F);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    en_in = 4'hF;
    value = 16'hBEE6;
    repeat (4) @(negedge clk);
    repeat (2) doStep();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Downstream consumer of the clock divider's slow output.
- Time-multiplexes a packed hex value onto a common-anode multi-digit 7-segment display, one digit per scan step.
- Samples the divided clock in the fast domain and steps on its rising edges.
- Inserts an anode-blanking gap between digits to suppress ghosting, and latches display data once per frame so a frame never tears.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
BLANK_CYCLES, 16, CLK_IN cycles with all anodes off after each digit step (0 allowed)

Ports:
CLK_IN  input  1  system clock; all logic on its rising edge
RST_IN  input  1  synchronous active-high reset
SCAN_CLK_IN  input  1  divided clock from the divider stage; not used as a clock
VALUE_IN  input  4*NUM_DIGITS  hex nibbles, digit 0 = bits [3:0]
DP_IN  input  NUM_DIGITS  decimal point request per digit, 1 = lit
DIGIT_EN_IN  input  NUM_DIGITS  per-digit enable, 0 = digit dark
LZB_IN  input  1  leading-zero blanking enable
AN_OUT  output  NUM_DIGITS  anode drives, active low
SEG_OUT  output  7  segments {g,f,e,d,c,b,a}, active low
DP_OUT  output  1  decimal point, active low
FRAME_OUT  output  1  one-cycle pulse when a new frame is latched

Behaviour:
- Single clock CLK_IN; reset RST_IN synchronous, active high.
- Reset values:
  - AN_OUT all 1; SEG_OUT 7'h7F; DP_OUT 1; FRAME_OUT 0.
  - Digit index = NUM_DIGITS-1; state BLANK; blank counter 0; shadow registers 0.
- Step detect:
  - SCAN_CLK_IN passes through a 2-FF synchronizer, then a rising-edge detect against the previous synchronized value.
  - The resulting step pulse is asserted 3 CLK_IN edges after SCAN_CLK_IN rises.
  - A falling edge is not a step.
- On a step:
  - Digit index increments, wrapping NUM_DIGITS-1 -> 0.
  - State -> BLANK; counter <= BLANK_CYCLES; AN_OUT all 1 in the same cycle.
- Frame latch (index wraps to 0):
  - VALUE_IN, DP_IN, DIGIT_EN_IN and LZB_IN are copied into shadow registers.
  - FRAME_OUT = 1 for exactly that cycle.
  - The first step after reset always latches, because index starts at NUM_DIGITS-1.
- States:
  - BLANK: counter decrements each cycle. When counter = 0 (immediately if BLANK_CYCLES = 0), next state is DRIVE.
  - DRIVE: AN_OUT[index] = 0 if the digit is visible, all other anodes 1.
  - DRIVE holds until the next step.
  - A step arriving during BLANK re-enters BLANK with the counter reloaded.
- Outputs in DRIVE:
  - SEG_OUT = decode(shadow nibble[index]).
  - DP_OUT = ~shadow_DP[index].
  - Both are registered, so they change in the same cycle AN_OUT goes low.
- Outputs in BLANK: AN_OUT all 1, SEG_OUT 7'h7F, DP_OUT 1.
- Visibility: a digit is visible iff shadow_EN[index] = 1 and it is not leading-blanked.
- Leading-zero blanking (shadow_LZB = 1):
  - A digit is blanked if it and every higher-index digit are 0.
  - Digit 0 is never leading-blanked.
  - A blanked digit drives AN, SEG and DP off.
- Decode table (active low, {g..a}):
  0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000,
  8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Reset mid-frame: all outputs go to reset values on the next edge and the scan restarts from the latch step.
- Input changes mid-frame have no effect until the next frame latch.

Decomposition:
- Package seven_seg_pkg holds:
  - state enum {BLANK, DRIVE};
  - SEG_OFF = 7'h7F;
  - the 16-entry decode constants.
- Sub-module hex_to_seg7: combinational nibble -> active-low segment decoder, instantiated once on the selected shadow nibble.
- Synchronizer, edge detect, FSM and leading-zero logic stay in seven_seg_scanner.

Test Plan:
- Reset, then hold RST_IN 1 with SCAN_CLK_IN toggling -> AN_OUT=4'hF, SEG_OUT=7'h7F, DP_OUT=1, FRAME_OUT=0 throughout.
- VALUE_IN=16'h12AF, all enabled, LZB=0, first step -> FRAME_OUT pulse, then AN_OUT=4'hF for 16 cycles, then AN_OUT=4'b1110, SEG_OUT=0001110 ('F'); subsequent steps show A, 2, 1 on AN 1101, 1011, 0111.
- VALUE_IN=16'h0005, LZB=1 -> digits 3..1 dark (AN all 1 in their DRIVE slots), digit 0 AN=1110, SEG=0010010; VALUE_IN=16'h0000 -> digit 0 still shows 1000000.
- Change VALUE_IN 16'h1111 -> 16'h2222 while index=1 -> digits 2 and 3 still show '1'; '2' appears only after the next FRAME_OUT.
- Two steps 5 cycles apart with BLANK_CYCLES=16 -> DRIVE never entered between them, index advances by 2, counter reloads on the second step.
- BLANK_CYCLES=0, DP_IN=4'b0100 -> AN goes low one cycle after the step; DP_OUT=0 only in digit 2's slot. Also assert RST_IN mid-DRIVE -> outputs at reset values on the next edge and the next step latches a new frame.
